// File: rtl/message_bus_mailbox_slave.sv
// -----------------------------------------------------------------------------
// message_bus_mailbox_slave
//   Responder end of the event-unit message bus. It holds a DEPTH-entry,
//   32-bit message FIFO that initiators push to and pop from through register
//   accesses. Every granted access gets exactly one response in the following
//   cycle, tagged with the request id. irq_o is high while messages are
//   pending and the interrupt is enabled.
//
// Register map (add_i[4:2]):
//   0 PUSH (W)  1 POP (R)  2 STAT (R)  3 CLEAR (W)  4 IRQEN (R/W)  5 DROP (R)
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i                 request valid; gnt_o mirrors it (never stalls)
//   add_i                 byte address, only bits [4:2] decoded
//   wen_i                 1 = read, 0 = write
//   wdata_i, be_i, id_i   write data, byte enables, initiator id
//   gnt_o                 grant
//   r_valid_o, r_opc_o    response valid, 0 = OK / 1 = error
//   r_id_o, r_rdata_o     echoed id, read data (0 for writes and errors)
//   irq_o                 registered irq_en & ~empty
// -----------------------------------------------------------------------------
module message_bus_mailbox_slave #(
  parameter int ID_WIDTH = 9,
  parameter int DEPTH    = 8   // power of two, >= 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic                r_valid_o,
  output logic                r_opc_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [31:0]         r_rdata_o,
  output logic                irq_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] A_PUSH  = 3'd0;
  localparam logic [2:0] A_POP   = 3'd1;
  localparam logic [2:0] A_STAT  = 3'd2;
  localparam logic [2:0] A_CLEAR = 3'd3;
  localparam logic [2:0] A_IRQEN = 3'd4;
  localparam logic [2:0] A_DROP  = 3'd5;

  // Mailbox state
  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_drop;
  logic             r_irq_en;

  // Response stage registers
  logic                r_vld_p1;
  logic                r_opc_p1;
  logic [ID_WIDTH-1:0] r_id_p1;
  logic [31:0]         r_rdata_p1;
  logic                r_irq_p1;

  // Decode results
  logic        w_hs;
  logic [2:0]  w_addr;
  logic        w_full;
  logic        w_empty;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_push;
  logic        w_pop;
  logic        w_clear;
  logic        w_irqen_we;
  logic        w_drop_inc;
  logic        w_unused;

  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] f_stat_word(input logic full, input logic empty,
                                              input logic [CNT_W-1:0] cnt);
    return {full, empty, 14'b0, {(16-CNT_W){1'b0}}, cnt};
  endfunction

  assign gnt_o   = req_i;
  // A request seen while reset is asserted never reaches state or response.
  assign w_hs    = req_i & ~rst_i;
  assign w_addr  = add_i[4:2];
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Address bits outside [4:2] are intentionally ignored.
  assign w_unused = ^{add_i[31:5], add_i[1:0], be_i[3:1] & {3{wen_i}}, wdata_i[31:1] & {31{wen_i}}};

  always_comb begin
    w_err      = 1'b0;
    w_rdata    = '0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_clear    = 1'b0;
    w_irqen_we = 1'b0;
    w_drop_inc = 1'b0;
    case (w_addr)
      A_PUSH: begin
        if (wen_i) begin
          w_err = 1'b1;
        end else if (w_full) begin
          // Only full-FIFO rejections are counted as drops.
          w_err      = 1'b1;
          w_drop_inc = 1'b1;
        end else if (be_i != 4'hF) begin
          w_err = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end
      A_POP: begin
        if (!wen_i || w_empty) begin
          w_err = 1'b1;
        end else begin
          w_rdata = r_mem[r_rd_ptr];
          w_pop   = 1'b1;
        end
      end
      A_STAT: begin
        if (!wen_i) w_err = 1'b1;
        else        w_rdata = f_stat_word(w_full, w_empty, r_count);
      end
      A_CLEAR: begin
        if (wen_i) w_err = 1'b1;
        else       w_clear = 1'b1;
      end
      A_IRQEN: begin
        if (wen_i) w_rdata    = {31'b0, r_irq_en};
        else       w_irqen_we = be_i[0];
      end
      A_DROP: begin
        if (!wen_i) w_err = 1'b1;
        else        w_rdata = {16'b0, r_drop};
      end
      default: w_err = 1'b1;
    endcase
  end

  // ---- state update at the handshake edge ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_irq_en <= 1'b0;
    end else if (w_hs) begin
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_drop   <= '0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_count  <= r_count + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count  <= r_count - CNT_W'(1);
      end
      if (w_drop_inc) r_drop   <= f_sat_inc16(r_drop);
      if (w_irqen_we) r_irq_en <= wdata_i[0];
    end
  end

  // FIFO storage carries no reset; only slots between the pointers are read.
  always_ff @(posedge clk_i) begin
    if (w_hs && w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  // ---- response stage p1 ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1   <= 1'b0;
      r_opc_p1   <= 1'b0;
      r_id_p1    <= '0;
      r_rdata_p1 <= '0;
      r_irq_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_hs;
      if (w_hs) begin
        r_opc_p1   <= w_err;
        r_id_p1    <= id_i;
        r_rdata_p1 <= w_rdata;
      end
      // Sampled from registered state, so it trails a FIFO change by a cycle.
      r_irq_p1 <= r_irq_en & ~w_empty;
    end
  end

  assign r_valid_o = r_vld_p1;
  assign r_opc_o   = r_opc_p1;
  assign r_id_o    = r_id_p1;
  assign r_rdata_o = r_rdata_p1;
  assign irq_o     = r_irq_p1;

endmodule
